ysyx_icache: RTL



---
 rtl/ysyx_icache.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ysyx_icache.sv
// Direct-mapped read-only instruction cache: 16 lines x 4 words, refilled word 0..3
// through single-beat reads on the arbiter's IFU port; supports fence.i and hit/miss counters.
module ysyx_icache #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SET_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              req_ready_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    input  logic              fence_i,
    output logic [ADDR_W-1:0] bus_araddr_o,
    output logic              bus_arvalid_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_rvalid_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int unsigned Sets = 1 << SET_BITS;
    localparam int unsigned TagW = ADDR_W - 4 - SET_BITS;

    typedef enum logic [2:0] {StIdle, StLookup, StRefill, StGap, StResp} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_req_addr;
    logic [1:0]        r_cnt;
    logic [Sets-1:0]   r_valid;
    logic              r_poison;
    logic [DATA_W-1:0] r_inst;
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;
    logic [TagW-1:0]   r_tag  [Sets];
    logic [DATA_W-1:0] r_data [Sets][4];

    logic [TagW-1:0]     w_req_tag;
    logic [SET_BITS-1:0] w_req_idx;
    logic [1:0]          w_req_word;
    logic                w_hit;
    logic                w_accept;
    logic                w_inst_valid;
    logic [DATA_W-1:0]   w_line_word;
    logic                w_unused;

    assign w_req_tag   = r_req_addr[ADDR_W-1:4+SET_BITS];
    assign w_req_idx   = r_req_addr[3+SET_BITS:4];
    assign w_req_word  = r_req_addr[3:2];
    assign w_hit       = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_accept    = (r_state == StIdle) && pc_valid_i && !fence_i;
    assign w_line_word = r_data[w_req_idx][w_req_word];
    assign w_unused    = ^r_req_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_accept) w_state_next = StLookup;
            StLookup: w_state_next = w_hit ? StIdle : StRefill;
            StRefill: if (bus_rvalid_i) w_state_next = (r_cnt == 2'd3) ? StResp : StGap;
            StGap:    w_state_next = StRefill;
            StResp:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o   = (r_state == StIdle) && !fence_i;
        w_inst_valid  = ((r_state == StLookup) && w_hit) || (r_state == StResp);
        inst_valid_o  = w_inst_valid;
        inst_o        = w_inst_valid ? w_line_word : r_inst;
        bus_arvalid_o = (r_state == StRefill);
        bus_araddr_o  = '0;
        if (r_state == StRefill) begin
            bus_araddr_o = {w_req_tag, w_req_idx, r_cnt, 2'b00};
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_addr <= '0;
            r_cnt      <= '0;
            r_valid    <= '0;
            r_poison   <= 1'b0;
            r_inst     <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_accept) r_req_addr <= pc_i;
            if (r_state == StLookup) begin
                if (w_hit) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end else begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                    r_cnt      <= 2'd0;
                end
            end
            if ((r_state == StRefill) && bus_rvalid_i) r_cnt <= r_cnt + 2'd1;
            if (w_inst_valid) r_inst <= w_line_word;
            if (fence_i) r_valid <= '0;
            // A fence landing in the RESP cycle itself must also keep the line invalid.
            if (r_state == StResp) r_valid[w_req_idx] <= !(r_poison || fence_i);
            if (fence_i && (r_state inside {StRefill, StGap, StResp})) r_poison <= 1'b1;
            if ((w_state_next == StIdle) && (r_state != StIdle)) r_poison <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == StRefill) && bus_rvalid_i) r_data[w_req_idx][r_cnt] <= bus_rdata_i;
        if (r_state == StResp) r_tag[w_req_idx] <= w_req_tag;
    end

endmodule
